// File: rtl/hamming_pkg.sv
// Shared Hamming(7,4) definitions: FSM encoding, code dimensions and the
// syndrome/correction helpers used by both the receiver and the encoder side.
package hamming_pkg;

  localparam int CW_LEN   = 7;
  localparam int DATA_LEN = 4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RECV = 1'b1
  } rx_state_t;

  // Codeword bit cw[i-1] holds Hamming position i.
  function automatic logic [2:0] hamming_syndrome(input logic [CW_LEN-1:0] cw);
    return {cw[3] ^ cw[4] ^ cw[5] ^ cw[6],
            cw[1] ^ cw[2] ^ cw[5] ^ cw[6],
            cw[0] ^ cw[2] ^ cw[4] ^ cw[6]};
  endfunction

  // Data nibble {pos7,pos6,pos5,pos3} with the position named by syn inverted.
  function automatic logic [DATA_LEN-1:0] hamming_correct_data(input logic [CW_LEN-1:0] cw,
                                                              input logic [2:0]        syn);
    return {cw[6] ^ (syn == 3'd7),
            cw[5] ^ (syn == 3'd6),
            cw[4] ^ (syn == 3'd5),
            cw[2] ^ (syn == 3'd3)};
  endfunction

endpackage

// File: rtl/hamming_rx_s_if.sv
// Serial Hamming receiver bus. No back-pressure: d is taken in every cycle
// with s=1; valid and abort are single-cycle pulses. Stats port under HAMMING_RX_STATS_EN.
interface hamming_rx_s_if;
  logic       d;
  logic       s;
  logic [3:0] d_out;
  logic       valid;
  logic       err;
  logic [2:0] err_pos;
  logic       abort;
`ifdef HAMMING_RX_STATS_EN
  logic [7:0] corr_cnt;
`endif

  modport master (
    output d, s,
    input  d_out, valid, err, err_pos, abort
`ifdef HAMMING_RX_STATS_EN
    , input corr_cnt
`endif
  );

  modport slave (
    input  d, s,
    output d_out, valid, err, err_pos, abort
`ifdef HAMMING_RX_STATS_EN
    , output corr_cnt
`endif
  );
endinterface

// File: rtl/hamming_dec74_s.sv
// Combinational Hamming(7,4) decoder: syndrome, single-bit correction, data extraction.
module hamming_dec74_s
  import hamming_pkg::*;
(
  input  logic [CW_LEN-1:0]   cw,
  output logic [DATA_LEN-1:0] data,
  output logic                err,
  output logic [2:0]          syn
);

  always_comb begin
    syn  = hamming_syndrome(cw);
    data = hamming_correct_data(cw, syn);
    err  = (syn != 3'd0);
  end

endmodule

// File: rtl/hamming_rx_s.sv
// Serial Hamming(7,4) receiver with gap abort. Optional corrected-word counter
// enabled by HAMMING_RX_STATS_EN.
module hamming_rx_s
  import hamming_pkg::*;
#(
  parameter int GAP_MAX = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  hamming_rx_s_if.slave  bus,
  output rx_state_t      dbg_state
);

  localparam int IW = $clog2(GAP_MAX + 1);

  rx_state_t          state, state_nxt;
  logic [2:0]         bit_cnt, bit_cnt_nxt;
  logic [IW-1:0]      idle_cnt, idle_cnt_nxt;
  logic [CW_LEN-2:0]  sr, sr_nxt;
  logic               cw_load;
  logic               abort_nxt;
  logic [CW_LEN-1:0]  cw_q;
  logic               cw_done;

  logic [DATA_LEN-1:0] dec_data;
  logic                dec_err;
  logic [2:0]          dec_syn;

  assign dbg_state = state;

  // The first six bits live in sr (first bit ends at sr[0]); the seventh is
  // taken straight from the bus so the word can be latched on its strobe.
  always_comb begin
    state_nxt    = state;
    bit_cnt_nxt  = bit_cnt;
    idle_cnt_nxt = idle_cnt;
    sr_nxt       = sr;
    cw_load      = 1'b0;
    abort_nxt    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.s) begin
          state_nxt    = ST_RECV;
          bit_cnt_nxt  = 3'd1;
          idle_cnt_nxt = '0;
          sr_nxt       = {bus.d, 5'b0};
        end
      end
      ST_RECV: begin
        if (bus.s) begin
          sr_nxt       = {bus.d, sr[CW_LEN-2:1]};
          idle_cnt_nxt = '0;
          if (bit_cnt == 3'(CW_LEN - 1)) begin
            state_nxt   = ST_IDLE;
            bit_cnt_nxt = 3'd0;
            cw_load     = 1'b1;
          end else begin
            bit_cnt_nxt = bit_cnt + 3'd1;
          end
        end else if (idle_cnt == IW'(GAP_MAX - 1)) begin
          state_nxt    = ST_IDLE;
          bit_cnt_nxt  = 3'd0;
          idle_cnt_nxt = '0;
          sr_nxt       = '0;
          abort_nxt    = 1'b1;
        end else begin
          idle_cnt_nxt = idle_cnt + IW'(1);
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      bit_cnt  <= 3'd0;
      idle_cnt <= '0;
      sr       <= '0;
    end else begin
      state    <= state_nxt;
      bit_cnt  <= bit_cnt_nxt;
      idle_cnt <= idle_cnt_nxt;
      sr       <= sr_nxt;
    end
  end

  // Separate codeword holding register lets a new frame start while the
  // previous word is still being decoded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cw_q    <= '0;
      cw_done <= 1'b0;
    end else begin
      cw_done <= cw_load;
      if (cw_load) cw_q <= {bus.d, sr};
    end
  end

  hamming_dec74_s u_dec (
    .cw   (cw_q),
    .data (dec_data),
    .err  (dec_err),
    .syn  (dec_syn)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.valid   <= 1'b0;
      bus.abort   <= 1'b0;
      bus.err     <= 1'b0;
      bus.d_out   <= 4'h0;
      bus.err_pos <= 3'h0;
    end else begin
      bus.valid <= cw_done;
      bus.abort <= abort_nxt;
      if (cw_done) begin
        bus.d_out   <= dec_data;
        bus.err     <= dec_err;
        bus.err_pos <= dec_syn;
      end
    end
  end

`ifdef HAMMING_RX_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.corr_cnt <= 8'h00;
    end else if (cw_done && dec_err && (bus.corr_cnt != 8'hFF)) begin
      bus.corr_cnt <= bus.corr_cnt + 8'h01;
    end
  end
`endif

endmodule

// File: doc/hamming_rx_s.md
HAMMING_RX_S -- requirements
Module: hamming_rx_s

Interface
REQ-001 Parameter GAP_MAX, default 8: maximum consecutive idle cycles (s low) tolerated inside a frame before the frame is aborted.
REQ-002 Port clk, input, 1: sole clock; all state updates on the rising edge.
REQ-003 Port rst_n, input, 1: asynchronous, active-low reset.
REQ-004 Port d, input, 1: serial codeword bit, sampled only when s=1.
REQ-005 Port s, input, 1: bit strobe; d is valid in any cycle with s=1.
REQ-006 Port d_out, output, 4: corrected data nibble {d4,d3,d2,d1}.
REQ-007 Port valid, output, 1: one-cycle pulse; d_out, err and err_pos are valid in that cycle.
REQ-008 Port err, output, 1: a single-bit error was detected and corrected in the delivered word.
REQ-009 Port err_pos, output, 3: syndrome, i.e. corrected bit position 1..7; 0 means no error.
REQ-010 Port abort, output, 1: one-cycle pulse when a partial frame is discarded.

Function
REQ-011 Frame format: 7 strobed bits, first-received bit is Hamming position 1, in the order p1,p2,d1,p4,d2,d3,d4.
REQ-012 FSM states:
- IDLE: wait for a strobe.
- RECV: bits 2..7 being collected.
REQ-013 IDLE -> RECV on s=1; the first bit is captured and the bit counter is set to 1.
REQ-014 In RECV, each s=1 shifts d into the shift register and increments the counter. When the 7th bit arrives, the FSM returns to IDLE.
REQ-015 Syndrome: S[0]=pos1^pos3^pos5^pos7; S[1]=pos2^pos3^pos6^pos7; S[2]=pos4^pos5^pos6^pos7.
REQ-016 When S!=0, the bit at position S is inverted before data extraction. err=1 and err_pos=S.
REQ-017 d_out={pos7,pos6,pos5,pos3}, taken after correction.
REQ-018 Latency: the 7th bit is sampled at edge N; valid, d_out, err and err_pos are registered and visible after edge N+1 for exactly one cycle.
REQ-019 d_out, err and err_pos hold their last values between valid pulses.
REQ-020 Back-to-back frames: if s=1 in the cycle immediately after the 7th bit, that bit is position 1 of the next frame, with no lost bits.
REQ-021 Gap handling: in RECV, an idle counter increments on each s=0 cycle and clears on s=1.
REQ-022 When the idle count reaches GAP_MAX: the FSM goes to IDLE, the partial data is discarded, abort pulses for one cycle, and valid is not asserted.
REQ-023 An idle gap of GAP_MAX-1 cycles does not abort the frame.
REQ-024 Double-bit errors are outside the code's guarantee. Behaviour is exactly REQ-015..017, with no special detection.

Reset
REQ-025 rst_n=0 asynchronously forces:
- FSM to IDLE;
- bit counter, idle counter and shift register to 0;
- valid, abort and err to 0;
- d_out to 4'h0 and err_pos to 3'h0.
REQ-026 A reset asserted mid-frame discards the partial frame without asserting abort. Reception restarts from position 1 at the first strobe after release.

Configuration
REQ-027 Macro HAMMING_RX_STATS_EN controls an error counter.
REQ-028 When defined: output corr_cnt [7:0] counts valid pulses with err=1, saturates at 8'hFF and resets to 0.
REQ-029 When undefined: the port and the counter are absent, and all other behaviour is identical.

Structure
REQ-030 Shared package hamming_pkg contains:
- the FSM state encoding;
- constants CW_LEN=7 and DATA_LEN=4;
- the syndrome/correction function, reused by the encoder side.
REQ-031 One sub-module, hamming_dec74_s, is combinational: 7-bit codeword in; 4-bit data, error flag and syndrome out. The FSM and registers stay in hamming_rx_s.

Verification
REQ-032 Clean frame: send bits 1,0,1,0,1,0,1 on consecutive strobes -> one cycle later valid=1, d_out=4'b1011, err=0, err_pos=0.
REQ-033 Single-bit error: send 1,0,1,0,0,0,1 (position 5 flipped) -> valid=1, d_out=4'b1011, err=1, err_pos=5. With HAMMING_RX_STATS_EN defined, corr_cnt goes 0->1.
REQ-034 Back-to-back: send two clean 1011 frames as 14 consecutive strobes -> two valid pulses 7 cycles apart, both d_out=4'b1011.
REQ-035 Gap abort (GAP_MAX=8): send 3 bits, hold s=0 for 8 cycles -> abort pulses once, no valid; a following clean frame decodes to 1011. A gap of 7 cycles instead yields a normal valid pulse.
REQ-036 Reset mid-frame: pulse rst_n low after 4 bits -> outputs reset to 0 with no abort; a subsequent full clean frame decodes correctly.
